// File: rtl/irq_pending_latch.sv
// Synchronises four request lines into pending bits and presents a frozen masked snapshot.
// IRQ_EDGE_LATCH_EN selects sticky edge-latched pending bits; undefined gives level mode.
module irq_pending_latch #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq_in,
    input  logic [3:0] mask,
    output logic [3:0] snap,
    input  logic [1:0] sel_in,
    output logic       valid,
    output logic [1:0] idx,
    input  logic       ack,
    output logic [3:0] miss,
    input  logic       miss_clr
);

    typedef enum logic {StIdle, StPresent} state_e;

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] s;
    logic [3:0] pending_q;
    state_e     state_q;
    logic       first_q;
    logic [3:0] snap_q;
    logic [1:0] idx_q;
    logic       accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < int'(SYNC_STAGES); j++) begin
                sync_q[j] <= '0;
            end
        end else begin
            sync_q[0] <= irq_in;
            for (int j = 1; j < int'(SYNC_STAGES); j++) begin
                sync_q[j] <= sync_q[j-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The first PRESENT cycle holds off ack so idx can be captured from the encoder first.
    assign accept = (state_q == StPresent) && !first_q && ack;

`ifdef IRQ_EDGE_LATCH_EN
    logic [3:0] s_d_q;
    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] pending_d;
    logic [3:0] miss_q;
    logic [3:0] miss_d;

    always_comb begin
        rise      = s & ~s_d_q;
        clr       = accept ? (4'b0001 << idx_q) : 4'b0000;
        // A new edge wins over the ack clear on the same bit.
        pending_d = (pending_q & ~clr) | rise;
        miss_d    = (miss_q & ~{4{miss_clr}}) | (rise & pending_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_d_q     <= '0;
            pending_q <= '0;
            miss_q    <= '0;
        end else begin
            s_d_q     <= s;
            pending_q <= pending_d;
            miss_q    <= miss_d;
        end
    end

    assign miss = miss_q;
`else
    logic unused_miss_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= s;
        end
    end

    assign miss            = 4'b0000;
    assign unused_miss_clr = miss_clr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            first_q <= 1'b0;
            snap_q  <= '0;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|(pending_q & mask)) begin
                        state_q <= StPresent;
                        first_q <= 1'b1;
                        snap_q  <= pending_q & mask;
                    end
                end
                StPresent: begin
                    first_q <= 1'b0;
                    if (first_q) begin
                        idx_q <= sel_in;
                    end
                    if (accept) begin
                        state_q <= StIdle;
                        snap_q  <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign snap  = snap_q;
    assign valid = (state_q == StPresent);
    assign idx   = idx_q;

endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Upstream stage of the 4-to-2 priority encoder: it synchronises four asynchronous request lines, records them as sticky pending bits, and masks them. It presents a frozen 4-bit snapshot to the encoder's D input, reads back the encoder's 2-bit code, and clears the selected pending bit when the consumer acknowledges. This keeps the encoder input stable for the whole handshake and ensures no request is lost between service cycles.

## Interface
- SYNC_STAGES, 2, number of flops in each irq_in synchroniser chain (legal range 2..4).
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  4  asynchronous request lines; bit 3 has the highest priority downstream.
- mask  input  4  per-line enable; 1 means the line is enabled.
- snap  output  4  frozen masked-pending vector; drives the encoder's D input.
- sel_in  input  2  encoder Y output, fed back combinationally from snap.
- valid  output  1  high while snap holds a non-zero request awaiting service.
- idx  output  2  equals sel_in, captured in the same cycle valid rises; held stable while valid is high.
- ack  input  1  consumer accepts the request; only meaningful while valid is high.
- miss  output  4  sticky flag per line: a new edge arrived while that line's pending bit was already set.
- miss_clr  input  1  clears all miss bits.

## Operation
- Synchroniser: irq_in[i] passes through SYNC_STAGES flops, producing s[i]. One further flop holds s_d[i] for edge detection.
- Edge event: rise[i] = s[i] & ~s_d[i].
- pending[i] is set by rise[i] and cleared by an accepted ack when idx == i. If set and clear coincide on the same bit, set wins.
- miss[i] is set when rise[i] occurs and pending[i] is already 1 and is not cleared in that cycle. miss_clr clears all miss bits; if miss_clr and a new miss coincide, the set wins.
- FSM, two states:
  - IDLE → PRESENT when (pending & mask) != 0. On that edge: snap <= pending & mask.
  - PRESENT → IDLE on valid & ack. On that edge: pending[idx] is cleared and snap <= 0.
  - PRESENT holds otherwise. snap is not updated by later pending or mask changes.
- valid = (state == PRESENT).
- idx is registered from sel_in on the first PRESENT cycle and then held. The encoder output is never consumed in IDLE.
- ack while in IDLE is ignored.
- Masked lines still set pending bits and are presented once their mask bit is 1.

## Timing
- Reset values: snap = 0, valid = 0, idx = 0, miss = 0, pending = 0, all synchroniser and edge flops = 0, state = IDLE.
- rst has priority over every other input. Reset during PRESENT drops valid on the next edge and discards the request.
- Request latency: irq_in rising before edge 0 → s high after edge SYNC_STAGES−1 → pending set at edge SYNC_STAGES → valid high after edge SYNC_STAGES+1. That is 3 edges with the default setting.
- idx is valid one cycle after valid rises. The consumer must not sample idx in the first valid cycle.
- Accepting ack is legal from the second valid cycle onward. An ack in the first valid cycle is held off: it is ignored, and the consumer must hold ack high.
- After an accepted ack: valid is low for at least one cycle (the IDLE cycle), then re-presents if any masked pending bits remain. Back-to-back service therefore takes 3 cycles per request.
- Pulses on irq_in shorter than one clk period may be missed; this is permitted.

## Configuration
- IRQ_EDGE_LATCH_EN defined (edge mode): behaviour exactly as above; pending bits are sticky, set by edges, and cleared only by ack.
- IRQ_EDGE_LATCH_EN undefined (level mode):
  - pending = s every cycle; the edge flop and clear logic are removed.
  - miss is tied to 0.
  - ack still moves PRESENT → IDLE, but does not clear anything; a line that is still high re-presents.

## Test plan
- Reset: hold rst for 2 cycles with irq_in = 4'b1111 → snap = 0, valid = 0, miss = 0 throughout reset; valid rises 3 edges after rst falls (edge mode).
- Single request: irq_in[1] rises, mask = 4'b1111 → valid high after 3 edges, snap = 4'b0010, idx = 2'b01; ack → pending clears and valid drops.
- Priority and hold: irq_in[0] and irq_in[2] rise in the same cycle → snap = 4'b0101, idx = 2'b10; after ack, the next presentation is snap = 4'b0001, idx = 2'b00.
- Snapshot freeze: in PRESENT with snap = 4'b0001, irq_in[3] rises → snap and idx stay unchanged until ack; next presentation is snap = 4'b1000, idx = 2'b11.
- Mask and miss: mask = 4'b0000, irq_in[2] pulses twice → valid stays 0 and miss = 4'b0100; set mask = 4'b0100 → snap = 4'b0100; miss_clr → miss = 0.
- Reset mid-handshake: assert rst in PRESENT with no ack → valid = 0 next edge, pending = 0, no re-presentation afterwards.
